// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, one-entry output register to decode.
// Zero-wait memory gives one instruction per cycle; Stall parks the word in HOLD, Redirect squashes.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_target,
  output logic [31:0] o_instruction,
  output logic        o_instr_valid,
  output logic [31:0] o_pc_out,
  output logic [31:0] o_pc_plus4
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_target;
  logic [31:0] r_instr;
  logic        r_valid;
  logic [31:0] r_pc_out;
  logic        r_first;

  logic        w_ack;
  logic [31:0] w_tgt;
  logic        w_unused_tgt;

  // An ack in the first cycle after reset belongs to the abandoned pre-reset request.
  assign w_ack        = i_imem_ack & ~r_first;
  assign w_tgt        = {i_redirect_target[31:2], 2'b00};
  assign w_unused_tgt = ^i_redirect_target[1:0];

  assign o_imem_req    = ~i_reset & (r_state != HOLD);
  assign o_imem_addr   = r_pc;
  assign o_instruction = r_instr;
  assign o_instr_valid = r_valid;
  assign o_pc_out      = r_pc_out;
  assign o_pc_plus4    = r_pc_out + 32'd4;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_target <= RESET_PC;
      r_instr  <= 32'b0;
      r_valid  <= 1'b0;
      r_pc_out <= 32'b0;
      r_first  <= 1'b1;
    end else begin
      r_first <= 1'b0;
      case (r_state)
        FETCH: begin
          if (i_redirect) begin
            r_valid <= 1'b0;
            r_instr <= 32'b0;
            if (w_ack) begin
              r_pc <= w_tgt;
            end else begin
              r_target <= w_tgt;
              r_state  <= DROP;
            end
          end else if (r_valid && i_stall) begin
            // Output register is full: any word returned now is dropped and refetched later.
            r_state <= HOLD;
          end else if (w_ack) begin
            r_instr  <= i_imem_data;
            r_pc_out <= r_pc;
            r_valid  <= 1'b1;
            r_pc     <= r_pc + 32'd4;
          end else begin
            r_valid <= 1'b0;
            r_instr <= 32'b0;
          end
        end
        HOLD: begin
          if (i_redirect) begin
            r_state <= FETCH;
            r_pc    <= w_tgt;
            r_valid <= 1'b0;
            r_instr <= 32'b0;
          end else if (!i_stall) begin
            r_state <= FETCH;
            r_valid <= 1'b0;
            r_instr <= 32'b0;
          end
        end
        DROP: begin
          if (w_ack) begin
            r_state <= FETCH;
            r_pc    <= i_redirect ? w_tgt : r_target;
          end else if (i_redirect) begin
            r_target <= w_tgt;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, wait states, stall/hold, redirect cases, reset and PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, ack, stall, redir, valid;
  logic [31:0] addr, data, tgt, instr, pcout, pcp4;

  logic        rst2, req2, ack2, valid2;
  logic [31:0] addr2, data2, instr2, pcout2, pcp42;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .i_clock(clk), .i_reset(rst), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_ack(ack), .i_imem_data(data), .i_stall(stall), .i_redirect(redir),
    .i_redirect_target(tgt), .o_instruction(instr), .o_instr_valid(valid),
    .o_pc_out(pcout), .o_pc_plus4(pcp4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .i_clock(clk), .i_reset(rst2), .o_imem_req(req2), .o_imem_addr(addr2),
    .i_imem_ack(ack2), .i_imem_data(data2), .i_stall(1'b0), .i_redirect(1'b0),
    .i_redirect_target(32'h0), .o_instruction(instr2), .o_instr_valid(valid2),
    .o_pc_out(pcout2), .o_pc_plus4(pcp42)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic [31:0] d, input logic s,
                       input logic r, input logic [31:0] t);
    ack = a; data = d; stall = s; redir = r; tgt = t;
    #1;
  endtask

  task automatic out(input string tag, input logic v, input logic [31:0] i,
                     input logic [31:0] p, input logic q, input logic [31:0] a);
    chk({tag, "_valid"}, {31'b0, valid}, {31'b0, v});
    chk({tag, "_instr"}, instr, i);
    chk({tag, "_pcout"}, pcout, p);
    chk({tag, "_req"}, {31'b0, req}, {31'b0, q});
    chk({tag, "_addr"}, addr, a);
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; ack2 = 1'b1; data2 = 32'hABCD_0001;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    out("reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("reset_pcplus4", pcp4, 32'h4);
    chk("wrap_reset_addr", addr2, 32'hFFFF_FFFC);

    // First cycle after reset: request up, stale ack ignored.
    rst = 1'b0; rst2 = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    chk("post_reset_req", {31'b0, req}, 32'h1);
    chk("post_reset_addr", addr, 32'h0);
    tick();
    out("stale_ack", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    chk("wrap_stale_valid", {31'b0, valid2}, 32'h0);

    drive(1'b1, 32'h2008_0001, 1'b0, 1'b0, 32'h0);
    tick();
    out("w0", 1'b1, 32'h2008_0001, 32'h0, 1'b1, 32'h4);
    chk("w0_pcplus4", pcp4, 32'h4);
    chk("wrap_pcout", pcout2, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", pcp42, 32'h0);
    chk("wrap_next_addr", addr2, 32'h0);
    drive(1'b1, 32'h2009_0002, 1'b0, 1'b0, 32'h0);
    tick();
    out("w1", 1'b1, 32'h2009_0002, 32'h4, 1'b1, 32'h8);
    chk("w1_pcplus4", pcp4, 32'h8);
    drive(1'b1, 32'h200A_0003, 1'b0, 1'b0, 32'h0);
    tick();
    out("w2", 1'b1, 32'h200A_0003, 32'h8, 1'b1, 32'hC);
    chk("w2_pcplus4", pcp4, 32'hC);

    // Two wait states on the fetch from 0xC.
    drive(1'b0, 32'h9999_9999, 1'b0, 1'b0, 32'h0);
    tick();
    out("wait1", 1'b0, 32'h0, 32'h8, 1'b1, 32'hC);
    tick();
    out("wait2", 1'b0, 32'h0, 32'h8, 1'b1, 32'hC);
    drive(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
    tick();
    out("w3", 1'b1, 32'h1111_1111, 32'hC, 1'b1, 32'h10);

    // Stall 3 cycles; word returned in the stall cycle must be dropped and refetched.
    drive(1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h0);
    tick();
    out("hold1", 1'b1, 32'h1111_1111, 32'hC, 1'b0, 32'h10);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    out("hold2", 1'b1, 32'h1111_1111, 32'hC, 1'b0, 32'h10);
    tick();
    out("hold3", 1'b1, 32'h1111_1111, 32'hC, 1'b0, 32'h10);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    out("release", 1'b0, 32'h0, 32'hC, 1'b1, 32'h10);

    // Redirect with the 0x10 request outstanding.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
    tick();
    out("drop1", 1'b0, 32'h0, 32'hC, 1'b1, 32'h10);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    out("drop2", 1'b0, 32'h0, 32'hC, 1'b1, 32'h10);
    drive(1'b1, 32'hBADB_AD10, 1'b0, 1'b0, 32'h0);
    tick();
    out("drop_ack", 1'b0, 32'h0, 32'hC, 1'b1, 32'h100);
    drive(1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
    tick();
    out("tgt100", 1'b1, 32'h3333_3333, 32'h100, 1'b1, 32'h104);

    // Redirect coinciding with ack.
    drive(1'b1, 32'h4444_4444, 1'b0, 1'b1, 32'h0000_0200);
    tick();
    out("redir_ack", 1'b0, 32'h0, 32'h100, 1'b1, 32'h200);
    drive(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
    tick();
    out("tgt200", 1'b1, 32'h5555_5555, 32'h200, 1'b1, 32'h204);

    // Redirect while in HOLD squashes the held word.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    out("hold_b", 1'b1, 32'h5555_5555, 32'h200, 1'b0, 32'h204);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0300);
    tick();
    out("redir_hold", 1'b0, 32'h0, 32'h200, 1'b1, 32'h300);

    // Second redirect while in DROP replaces the target.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0400);
    tick();
    out("drop_a", 1'b0, 32'h0, 32'h200, 1'b1, 32'h300);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0502);
    tick();
    out("drop_b", 1'b0, 32'h0, 32'h200, 1'b1, 32'h300);
    drive(1'b1, 32'h6666_6666, 1'b0, 1'b0, 32'h0);
    tick();
    out("drop_b_ack", 1'b0, 32'h0, 32'h200, 1'b1, 32'h500);
    drive(1'b1, 32'h7777_7777, 1'b0, 1'b0, 32'h0);
    tick();
    out("tgt500", 1'b1, 32'h7777_7777, 32'h500, 1'b1, 32'h504);
    chk("tgt500_pcplus4", pcp4, 32'h504);

    // Reset pulse in the middle of a wait.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    out("pre_rst_wait", 1'b0, 32'h0, 32'h500, 1'b1, 32'h504);
    rst = 1'b1;
    tick();
    out("mid_rst", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    drive(1'b1, 32'h8888_8888, 1'b0, 1'b0, 32'h0);
    chk("after_rst_req", {31'b0, req}, 32'h1);
    tick();
    out("after_rst_ack", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned).
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 ImemReq  output  1  instruction-memory request valid.
REQ-005 ImemAddr  output  32  word address of the current request.
REQ-006 ImemAck  input  1  memory returns ImemData this cycle for the outstanding request.
REQ-007 ImemData  input  32  instruction word, valid only when ImemAck=1.
REQ-008 Stall  input  1  decode cannot accept Instruction this cycle.
REQ-009 Redirect  input  1  one-cycle pulse: jump/branch taken, refetch from RedirectTarget.
REQ-010 RedirectTarget  input  32  new PC; bits [1:0] ignored and forced to 00.
REQ-011 Instruction  output  32  word presented to decode; 32'b0 (NoOp) whenever InstrValid=0.
REQ-012 InstrValid  output  1  Instruction holds a real fetched word.
REQ-013 PCOut  output  32  address Instruction was fetched from.
REQ-014 PCPlus4  output  32  PCOut+4, used for JAL/JALR link writes.

Function
REQ-015 The block SHALL implement states FETCH, HOLD and DROP.
REQ-016 FETCH: ImemReq=1, ImemAddr=PC; ImemAddr SHALL remain stable until ImemAck is sampled high.
REQ-017 ImemAck in the same cycle as ImemReq rise SHALL be legal (zero-wait memory).
REQ-018 FETCH, ImemAck=1, no Redirect: next edge Instruction<=ImemData, PCOut<=PC, InstrValid<=1, PC<=PC+4.
REQ-019 Handover: Instruction is consumed on any edge where InstrValid=1 and Stall=0; with zero-wait memory and no Stall, throughput SHALL be one instruction per cycle.
REQ-020 InstrValid=1, Stall=1: Instruction, PCOut and InstrValid SHALL hold; state HOLD, ImemReq=0.
REQ-021 HOLD exits to FETCH on the first edge with Stall=0; the held word is consumed on that edge.
REQ-022 Consumed with no ImemAck that cycle: InstrValid<=0 and Instruction<=32'b0 on the next edge.
REQ-023 Stall with InstrValid=0 SHALL have no effect.
REQ-024 Redirect SHALL take priority over Stall and ImemAck: next edge InstrValid<=0, Instruction<=32'b0, PC<={RedirectTarget[31:2],2'b00}.
REQ-025 Redirect with ImemAck=1 in the same cycle: returned data discarded; state FETCH at the target.
REQ-026 Redirect with a request outstanding (ImemReq=1, ImemAck=0): state DROP; ImemReq stays 1 with the old ImemAddr until ImemAck, then the data is discarded and the state becomes FETCH at the target.
REQ-027 Redirect while in DROP SHALL replace the pending target and remain in DROP.
REQ-028 Redirect while in HOLD: state FETCH at the target; the held word is squashed.
REQ-029 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000, and PCPlus4 wraps the same way.
REQ-030 No word delivered in DROP SHALL ever reach Instruction.

Reset
REQ-031 While Reset=1: PC=RESET_PC, state FETCH, ImemReq=0, ImemAddr=RESET_PC, Instruction=0, InstrValid=0, PCOut=0, PCPlus4=4.
REQ-032 First cycle after Reset falls: ImemReq=1, ImemAddr=RESET_PC.
REQ-033 Reset mid-request SHALL abandon the request; an ImemAck arriving during Reset or in the first cycle after it SHALL be ignored.

Verification
REQ-034 Zero-wait memory, words 0x20080001,0x20090002,0x200A0003 at 0,4,8, Stall=0 -> InstrValid=1 on three consecutive cycles; PCOut=0,4,8; PCPlus4=4,8,C.
REQ-035 Two-wait-state memory -> ImemAddr stable across both waits; Instruction=0 with InstrValid=0 between deliveries.
REQ-036 Stall held 3 cycles while InstrValid=1 at PCOut=4 -> Instruction/PCOut held, ImemReq=0; after release next fetch ImemAddr=8.
REQ-037 Redirect to 0x00000103 with a request to 0x10 outstanding -> ack for 0x10 discarded; next ImemAddr=0x100; no word from 0x10 reaches Instruction.
REQ-038 Redirect and ImemAck in the same cycle, plus Redirect while in HOLD -> InstrValid=0 next cycle, ImemAddr=target.
REQ-039 RESET_PC=32'hFFFF_FFFC -> first PCOut=FFFF_FFFC, PCPlus4=0, next ImemAddr=0; Reset pulse mid-wait -> ImemAddr returns to RESET_PC.
